alt_vipcti131_common_read_prefetch: RTL and testbench
=====================================================

Name: alt_vipcti131_common_read_prefetch

Overview:
Memory-side read stage that sits directly upstream of the common unpack-data width adapter in the frame-reader path. Issues single-word Avalon-MM reads for a programmed run of words and buffers the returned data in a show-ahead FIFO. Presents that data to the unpacker with a stall flag (FIFO empty) and a pop request. Credit-based issue guarantees the FIFO never overflows; a clear input flushes buffered data and discards in-flight responses.

Parameters:
DATA_WIDTH, 128, memory word width; must be a multiple of 8
ADDR_WIDTH, 32, Avalon byte address width
COUNT_WIDTH, 24, width of the word-count input
DEPTH, 16, FIFO depth in words; power of two, at least 4
MAX_PENDING, 8, maximum outstanding reads; at most DEPTH

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that launches a run; ignored unless state is IDLE
start_addr  in  ADDR_WIDTH  byte address of the first word, word-aligned
word_count  in  COUNT_WIDTH  number of words in the run; 0 means no-op
busy  out  1  run in progress or responses pending
av_address  out  ADDR_WIDTH  Avalon read address
av_read  out  1  Avalon read request
av_waitrequest  in  1  Avalon slave stall
av_readdata  in  DATA_WIDTH  Avalon read data
av_readdatavalid  in  1  Avalon read data qualifier
data_out  out  DATA_WIDTH  FIFO head; valid whenever stall_out=0
stall_out  out  1  FIFO empty; drives the unpacker's stall_in
read_in  in  1  pop request; connects to the unpacker's read
clear  in  1  flush request; shares the unpacker's clear

Behaviour:
- Reset values: av_read=0, av_address=0, busy=0, stall_out=1, data_out=0; FIFO, counters and FSM cleared; state=IDLE.
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clock and reset.
- States: IDLE, ISSUE, FLUSH.
- IDLE: on start with word_count≠0, load addr=start_addr and remaining=word_count, then go to ISSUE. start with word_count=0 stays in IDLE.
- ISSUE, credit rule: assert av_read only if remaining>0, pending<MAX_PENDING and fill+pending<DEPTH.
  - fill is the FIFO count, log2(DEPTH)+1 bits.
  - pending is the outstanding-read count.
- Acceptance: a read is accepted when av_read=1 and av_waitrequest=0.
  - On acceptance: addr += DATA_WIDTH/8, remaining -= 1, pending += 1.
  - Address wraps modulo 2^ADDR_WIDTH.
- Avalon hold rule: once av_read=1 while av_waitrequest=1, av_read and av_address stay constant until accepted, even if credits change.
- readdatavalid: decrements pending. The word is pushed into the FIFO unless it is being discarded.
- Run completion: when remaining=0 and pending=0, go to IDLE.
- busy = (state≠IDLE).
- Consumer side, show-ahead FIFO:
  - pop = read_in & ~stall_out.
  - data_out is the head word. The next word appears in the cycle after a pop, with no bubble when fill>1.
  - Pop while empty is ignored.
- Push and pop in the same cycle leave fill unchanged. Push into an empty FIFO is visible (stall_out=0) the next cycle, giving 1-cycle latency from readdatavalid.
- clear, in any state: FIFO is emptied next cycle (stall_out=1) and remaining=0.
  - discard is loaded with pending, plus 1 if a read is accepted in the clear cycle.
  - A held av_read completes per the hold rule and its response is also counted into discard.
  - Next state is FLUSH if discard>0 or a read is still held; otherwise IDLE.
- FLUSH: each readdatavalid decrements discard and the word is dropped. Go to IDLE when discard=0 and no read is held. start is ignored in FLUSH.
- readdatavalid coincident with clear: the word is dropped and counted against discard.
- Simultaneous pop and clear: clear wins.
- Overflow is impossible by construction. The bench asserts fill ≤ DEPTH.

Decomposition:
- No shared package is needed. The local constants BYTES_PER_WORD and the FIFO address width derive from the parameters.
- One natural sub-module, alt_vipcti131_common_showahead_fifo: DATA_WIDTH × DEPTH, push/pop/flush, outputs empty and fill.
- The top level holds the FSM, the credit counters and the Avalon interface.

Test Plan:
- Zero-wait slave, start_addr=0x1000, word_count=4, read_in=1 constantly:
  - addresses 0x1000, 0x1010, 0x1020, 0x1030 issued on consecutive cycles;
  - 4 words appear in order;
  - busy falls after the last readdatavalid.
- Backpressure, DEPTH=16, read_in=0, word_count=40:
  - issue stops with fill+pending=16;
  - raise read_in and all 40 words arrive in order;
  - fill never exceeds 16.
- Slave latency 10 cycles, MAX_PENDING=8: pending never exceeds 8; throughput is 8 words per 10 cycles.
- av_waitrequest held 5 cycles on the 2nd read: av_address stays at 0x1010 and av_read stays 1 until accepted.
- clear with pending=3 and fill=5:
  - stall_out=1 next cycle;
  - 3 subsequent responses are dropped;
  - busy=0 after the 3rd;
  - a new start then returns only new data.
- Reset asserted mid-run with pending=2: outputs return to reset values immediately.

Source files
------------

// File: rtl/alt_vipcti131_common_read_prefetch_pkg.sv
// Shared constants for the frame-reader read-prefetch stage.
// Holds the run-FSM state encodings used by the top level.
// Kept as plain localparams so the encodings match older netlists.
package alt_vipcti131_common_read_prefetch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/alt_vipcti131_common_showahead_fifo.sv
// Purpose: show-ahead FIFO; the head word is presented combinationally whenever not empty.
// Latency: a push into an empty FIFO is visible the next cycle; no bubble between pops.
// Backpressure: none internally; the writer guarantees no overflow, and a pop while empty is ignored.
module alt_vipcti131_common_showahead_fifo #(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        i_push,
   input  logic [DATA_WIDTH-1:0]       i_push_dat,
   input  logic                        i_pop,
   input  logic                        i_flush,
   output logic [DATA_WIDTH-1:0]       o_head_dat,
   output logic                        o_empty,
   output logic [$clog2(DEPTH):0]      o_fill
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_fill;
   logic                  w_empty;
   logic                  w_pop;

   assign w_empty    = (r_fill == '0);
   assign w_pop      = i_pop & ~w_empty;
   assign o_empty    = w_empty;
   assign o_fill     = r_fill;
   // Empty FIFO reads as zero so the head is clean after reset or flush
   assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr];

   // Storage write; the array itself needs no reset since fill gates visibility
   always_ff @(posedge clock) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // Pointer and occupancy tracking; flush overrides any same-cycle push or pop
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_fill <= r_fill + (AW+1)'(i_push) - (AW+1)'(w_pop);
      end
   end

endmodule

// File: rtl/alt_vipcti131_common_read_prefetch.sv
// Purpose: issues single-word Avalon-MM reads for a programmed run and buffers returns for the unpacker.
// Latency: first read issues the cycle after start; returned words reach data_out one cycle after readdatavalid.
// Backpressure: reads are credit-limited so buffered plus outstanding words never exceed the FIFO depth.
module alt_vipcti131_common_read_prefetch
   import alt_vipcti131_common_read_prefetch_pkg::*;
#(
   parameter int DATA_WIDTH  = 128,
   parameter int ADDR_WIDTH  = 32,
   parameter int COUNT_WIDTH = 24,
   parameter int DEPTH       = 16,
   parameter int MAX_PENDING = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  start_addr,
   input  logic [COUNT_WIDTH-1:0] word_count,
   output logic                   busy,
   output logic [ADDR_WIDTH-1:0]  av_address,
   output logic                   av_read,
   input  logic                   av_waitrequest,
   input  logic [DATA_WIDTH-1:0]  av_readdata,
   input  logic                   av_readdatavalid,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   stall_out,
   input  logic                   read_in,
   input  logic                   clear
);

   localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int FIFO_AW        = $clog2(DEPTH);
   // One spare bit so pending plus a same-cycle acceptance never wraps
   localparam int PW             = $clog2(MAX_PENDING + 1) + 1;

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [COUNT_WIDTH-1:0] r_remaining;
   logic [COUNT_WIDTH-1:0] w_remaining_nxt;
   logic [PW-1:0]          r_pending;
   logic [PW-1:0]          w_pending_nxt;
   logic [PW-1:0]          r_discard;
   logic [PW-1:0]          w_discard_nxt;
   logic                   r_hold;
   logic                   w_hold_nxt;
   logic                   w_issue_ok;
   logic                   w_read;
   logic                   w_accept;
   logic                   w_load;
   logic                   w_push;
   logic                   w_empty;
   logic [FIFO_AW:0]       w_fill;

   // A stalled request must stay put until the slave takes it, so the hold flag
   // overrides the credit check and survives clear
   assign w_issue_ok = (r_state == ST_ISSUE) && (r_remaining != '0)
                    && (32'(r_pending) < 32'(MAX_PENDING))
                    && ((32'(w_fill) + 32'(r_pending)) < 32'(DEPTH));
   assign w_read     = r_hold | w_issue_ok;
   assign w_accept   = w_read & ~av_waitrequest;
   assign w_hold_nxt = w_read & av_waitrequest;
   assign w_load     = (r_state == ST_IDLE) & start & (word_count != '0) & ~clear;
   // Responses are dropped while flushing and in the cycle clear is asserted
   assign w_push     = av_readdatavalid & ~clear & (r_state != ST_FLUSH);

   assign av_read    = w_read;
   assign av_address = r_addr;
   assign busy       = (r_state != ST_IDLE);
   assign stall_out  = w_empty;

   // Next-state, credit and discard bookkeeping for the run FSM
   always_comb begin
      w_pending_nxt   = r_pending + PW'(w_accept) - PW'(av_readdatavalid);
      w_remaining_nxt = r_remaining;
      w_discard_nxt   = r_discard;
      w_state_nxt     = r_state;
      if (w_accept && (r_remaining != '0)) begin
         w_remaining_nxt = r_remaining - COUNT_WIDTH'(1);
      end
      case (r_state)
         ST_IDLE: begin
            if (w_load) begin
               w_remaining_nxt = word_count;
               w_state_nxt     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if ((w_remaining_nxt == '0) && (w_pending_nxt == '0)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            w_discard_nxt = r_discard + PW'(w_accept) - PW'(av_readdatavalid);
            if ((w_discard_nxt == '0) && !w_hold_nxt) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // Everything still outstanding after this cycle belongs to the abandoned run
      if (clear) begin
         w_remaining_nxt = '0;
         w_discard_nxt   = w_pending_nxt;
         w_state_nxt     = ((w_pending_nxt != '0) || w_hold_nxt) ? ST_FLUSH : ST_IDLE;
      end
   end

   // State, counters, hold flag and the word-stepping read address
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_pending   <= '0;
         r_discard   <= '0;
         r_hold      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_pending   <= w_pending_nxt;
         r_discard   <= w_discard_nxt;
         r_hold      <= w_hold_nxt;
         if (w_load) begin
            r_addr <= start_addr;
         end else if (w_accept) begin
            r_addr <= r_addr + ADDR_WIDTH'(BYTES_PER_WORD);
         end
      end
   end

   alt_vipcti131_common_showahead_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (av_readdata),
      .i_pop      (read_in & ~clear),
      .i_flush    (clear),
      .o_head_dat (data_out),
      .o_empty    (w_empty),
      .o_fill     (w_fill)
   );

endmodule

// File: tb/tb_alt_vipcti131_common_read_prefetch.sv
// Directed bench for the read-prefetch stage with a pipelined Avalon slave model.
// The slave returns a word derived from its address after a programmable latency.
// Each scenario task drives stimulus and checks its own expectations inline.
module tb_alt_vipcti131_common_read_prefetch;

   localparam int DW = 128;
   localparam int AW = 32;
   localparam int CW = 24;

   logic          clock;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [CW-1:0] word_count;
   logic          busy;
   logic [AW-1:0] av_address;
   logic          av_read;
   logic          av_waitrequest;
   logic [DW-1:0] av_readdata;
   logic          av_readdatavalid;
   logic [DW-1:0] data_out;
   logic          stall_out;
   logic          read_in;
   logic          clear;

   int tests = 0;
   int fails = 0;

   // Slave/collector state, written only by the env process
   int            nc = 0;
   int            n_acc = 0;
   int            n_ret = 0;
   int            last_rdv_nc = 0;
   int            wr_cnt = 0;
   logic          env_wreq;
   logic [AW-1:0] addr_log[$];
   logic [AW-1:0] w_addrs[$];
   logic          w_reads[$];
   logic [AW-1:0] q_addr[$];
   int            acc_nc[$];
   int            q_due[$];
   logic [DW-1:0] got[$];

   // Slave controls, written only by the main process
   int lat = 1;
   int wr_target = -1;
   int wr_len = 0;

   alt_vipcti131_common_read_prefetch dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .start_addr       (start_addr),
      .word_count       (word_count),
      .busy             (busy),
      .av_address       (av_address),
      .av_read          (av_read),
      .av_waitrequest   (av_waitrequest),
      .av_readdata      (av_readdata),
      .av_readdatavalid (av_readdatavalid),
      .data_out         (data_out),
      .stall_out        (stall_out),
      .read_in          (read_in),
      .clear            (clear)
   );

   function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
      return {~a, a ^ 32'h5a5a5a5a, a + 32'd7, a};
   endfunction

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "bench timeout");
   end

   // Avalon slave and consumer collector, acting mid-cycle on stable DUT outputs
   initial begin
      av_waitrequest   = 1'b0;
      av_readdatavalid = 1'b0;
      av_readdata      = '0;
      env_wreq         = 1'b0;
      forever begin
         @(negedge clock);
         nc++;
         if (reset) begin
            q_addr.delete();
            q_due.delete();
            av_readdatavalid = 1'b0;
            av_readdata      = '0;
            av_waitrequest   = 1'b0;
         end else begin
            if (read_in && !stall_out && !clear) got.push_back(data_out);
            env_wreq = (n_acc == wr_target) && (wr_cnt < wr_len) && (av_read || (wr_cnt != 0));
            if (env_wreq) begin
               wr_cnt++;
               w_addrs.push_back(av_address);
               w_reads.push_back(av_read);
            end
            av_waitrequest = env_wreq;
            if (av_read && !env_wreq) begin
               addr_log.push_back(av_address);
               acc_nc.push_back(nc);
               q_addr.push_back(av_address);
               q_due.push_back(nc + lat);
               n_acc++;
            end
            if ((q_due.size() > 0) && (q_due[0] <= nc)) begin
               av_readdatavalid = 1'b1;
               av_readdata      = mkdata(q_addr.pop_front());
               void'(q_due.pop_front());
               n_ret++;
               last_rdv_nc = nc;
            end else begin
               av_readdatavalid = 1'b0;
               av_readdata      = '0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input logic [AW-1:0] a, input logic [CW-1:0] n);
      start_addr = a;
      word_count = n;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) tick();
      tests++; if (av_read !== 1'b0) begin fails++; $display("FAIL rst_av_read: got %b want 0", av_read); end
      tests++; if (av_address !== 32'h0) begin fails++; $display("FAIL rst_av_address: got %h want 0", av_address); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
      tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL rst_stall_out: got %b want 1", stall_out); end
      tests++; if (data_out !== '0) begin fails++; $display("FAIL rst_data_out: got %h want 0", data_out); end
      reset = 1'b0;
      tick();
      do_start(32'h7000, 24'd0);
      tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_count_busy: got %b want 0", busy); end
      tests++; if (av_read !== 1'b0) begin fails++; $display("FAIL zero_count_read: got %b want 0", av_read); end
   endtask

   task automatic test_basic();
      int ab, gb;
      bit ok;
      lat = 1; read_in = 1'b1;
      ab = addr_log.size(); gb = got.size();
      do_start(32'h1000, 24'd4);
      wait_idle(60, ok);
      tests++; if (!ok) begin fails++; $display("FAIL basic_idle_timeout: busy %b want 0", busy); end
      tests++; if (last_rdv_nc !== nc) begin fails++; $display("FAIL basic_busy_fall: last rdv cycle %0d, busy fell at %0d", last_rdv_nc, nc); end
      repeat (3) tick();
      tests++; if (addr_log.size() - ab !== 4) begin fails++; $display("FAIL basic_nreads: got %0d want 4", addr_log.size() - ab); end
      tests++; if (got.size() - gb !== 4) begin fails++; $display("FAIL basic_nwords: got %0d want 4", got.size() - gb); end
      if ((addr_log.size() - ab == 4) && (got.size() - gb == 4)) begin
         for (int i = 0; i < 4; i++) begin
            tests++; if (addr_log[ab+i] !== 32'h1000 + 32'(16*i)) begin fails++; $display("FAIL basic_addr%0d: got %h want %h", i, addr_log[ab+i], 32'h1000 + 32'(16*i)); end
            tests++; if (acc_nc[ab+i] - acc_nc[ab] !== i) begin fails++; $display("FAIL basic_consec%0d: offset %0d want %0d", i, acc_nc[ab+i] - acc_nc[ab], i); end
            tests++; if (got[gb+i] !== mkdata(32'h1000 + 32'(16*i))) begin fails++; $display("FAIL basic_data%0d: got %h want %h", i, got[gb+i], mkdata(32'h1000 + 32'(16*i))); end
         end
      end
   endtask

   task automatic test_waitrequest();
      int ab, gb, wb;
      bit ok;
      lat = 1; read_in = 1'b1;
      ab = addr_log.size(); gb = got.size(); wb = w_addrs.size();
      wr_target = n_acc + 1;
      wr_len    = 5;
      do_start(32'h1000, 24'd4);
      wait_idle(60, ok);
      tests++; if (!ok) begin fails++; $display("FAIL wait_idle_timeout: busy %b want 0", busy); end
      repeat (3) tick();
      tests++; if (w_addrs.size() - wb !== 5) begin fails++; $display("FAIL wait_stall_cycles: got %0d want 5", w_addrs.size() - wb); end
      if (w_addrs.size() - wb == 5) begin
         for (int i = 0; i < 5; i++) begin
            tests++; if (w_addrs[wb+i] !== 32'h1010) begin fails++; $display("FAIL wait_hold_addr%0d: got %h want 00001010", i, w_addrs[wb+i]); end
            tests++; if (w_reads[wb+i] !== 1'b1) begin fails++; $display("FAIL wait_hold_read%0d: got %b want 1", i, w_reads[wb+i]); end
         end
      end
      tests++; if ((addr_log.size() - ab !== 4) || (got.size() - gb !== 4)) begin fails++; $display("FAIL wait_counts: reads %0d words %0d want 4 4", addr_log.size() - ab, got.size() - gb); end
      else begin
         for (int i = 0; i < 4; i++) begin
            tests++; if (addr_log[ab+i] !== 32'h1000 + 32'(16*i)) begin fails++; $display("FAIL wait_addr%0d: got %h want %h", i, addr_log[ab+i], 32'h1000 + 32'(16*i)); end
            tests++; if (got[gb+i] !== mkdata(32'h1000 + 32'(16*i))) begin fails++; $display("FAIL wait_data%0d: got %h want %h", i, got[gb+i], mkdata(32'h1000 + 32'(16*i))); end
         end
      end
      wr_target = -1;
   endtask

   task automatic test_backpressure();
      int ab, rb, gb, occ, maxocc;
      bit ok;
      lat = 1; read_in = 1'b0;
      ab = n_acc; rb = n_ret; gb = got.size(); maxocc = 0;
      do_start(32'h2000, 24'd40);
      for (int i = 0; i < 40; i++) begin
         tick();
         occ = (n_ret - rb) - (got.size() - gb);
         if (occ > maxocc) maxocc = occ;
      end
      tests++; if (n_acc - ab !== 16) begin fails++; $display("FAIL bp_issue_stop: accepted %0d want 16", n_acc - ab); end
      tests++; if (n_ret - rb !== 16) begin fails++; $display("FAIL bp_returned: got %0d want 16", n_ret - rb); end
      tests++; if (av_read !== 1'b0) begin fails++; $display("FAIL bp_read_low: got %b want 0", av_read); end
      tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL bp_stall: got %b want 0", stall_out); end
      read_in = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         tick();
         occ = (n_ret - rb) - (got.size() - gb);
         if (occ > maxocc) maxocc = occ;
         if ((got.size() - gb == 40) && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      tests++; if (!ok) begin fails++; $display("FAIL bp_drain_timeout: words %0d want 40", got.size() - gb); end
      tests++; if (maxocc !== 16) begin fails++; $display("FAIL bp_max_fill: got %0d want 16", maxocc); end
      if (got.size() - gb == 40) begin
         for (int i = 0; i < 40; i++) begin
            tests++; if (got[gb+i] !== mkdata(32'h2000 + 32'(16*i))) begin fails++; $display("FAIL bp_data%0d: got %h want %h", i, got[gb+i], mkdata(32'h2000 + 32'(16*i))); end
         end
      end
   endtask

   task automatic test_latency();
      int ab, rb, gb, pend, maxpend, t0;
      bit ok;
      lat = 10; read_in = 1'b1;
      ab = n_acc; rb = n_ret; gb = got.size(); maxpend = 0;
      do_start(32'h3000, 24'd32);
      t0 = nc;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         pend = (n_acc - ab) - (n_ret - rb);
         if (pend > maxpend) maxpend = pend;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      tests++; if (!ok) begin fails++; $display("FAIL lat_idle_timeout: busy %b want 0", busy); end
      tests++; if (maxpend !== 8) begin fails++; $display("FAIL lat_max_pending: got %0d want 8", maxpend); end
      tests++; if (nc - t0 > 56) begin fails++; $display("FAIL lat_throughput: run took %0d cycles, want at most 56", nc - t0); end
      repeat (3) tick();
      tests++; if (got.size() - gb !== 32) begin fails++; $display("FAIL lat_nwords: got %0d want 32", got.size() - gb); end
      else begin
         for (int i = 0; i < 32; i++) begin
            tests++; if (got[gb+i] !== mkdata(32'h3000 + 32'(16*i))) begin fails++; $display("FAIL lat_data%0d: got %h want %h", i, got[gb+i], mkdata(32'h3000 + 32'(16*i))); end
         end
      end
   endtask

   task automatic test_clear();
      int ab, rb, gb;
      bit ok;
      lat = 10; read_in = 1'b0;
      ab = n_acc; rb = n_ret; gb = got.size();
      do_start(32'h4000, 24'd8);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (n_ret - rb == 5) begin
            ok = 1'b1;
            break;
         end
      end
      tests++; if (!ok) begin fails++; $display("FAIL clr_setup_timeout: returned %0d want 5", n_ret - rb); end
      tests++; if ((n_acc - ab) - (n_ret - rb) !== 3) begin fails++; $display("FAIL clr_pending: got %0d want 3", (n_acc - ab) - (n_ret - rb)); end
      tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL clr_pre_stall: got %b want 0", stall_out); end
      clear = 1'b1; read_in = 1'b1;
      tick();
      clear = 1'b0;
      tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL clr_stall_next: got %b want 1", stall_out); end
      wait_idle(40, ok);
      tests++; if (!ok) begin fails++; $display("FAIL clr_flush_timeout: busy %b want 0", busy); end
      tests++; if (n_ret - rb !== 8) begin fails++; $display("FAIL clr_drop_count: returned %0d want 8 when idle", n_ret - rb); end
      tests++; if (last_rdv_nc !== nc) begin fails++; $display("FAIL clr_busy_fall: last rdv cycle %0d, busy fell at %0d", last_rdv_nc, nc); end
      repeat (3) tick();
      tests++; if (got.size() - gb !== 0) begin fails++; $display("FAIL clr_leak: %0d stale words popped, want 0", got.size() - gb); end
      tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL clr_post_stall: got %b want 1", stall_out); end
      lat = 1;
      gb = got.size();
      do_start(32'h5000, 24'd3);
      wait_idle(40, ok);
      repeat (3) tick();
      tests++; if (!ok || (got.size() - gb !== 3)) begin fails++; $display("FAIL clr_restart_count: words %0d want 3", got.size() - gb); end
      else begin
         for (int i = 0; i < 3; i++) begin
            tests++; if (got[gb+i] !== mkdata(32'h5000 + 32'(16*i))) begin fails++; $display("FAIL clr_restart_data%0d: got %h want %h", i, got[gb+i], mkdata(32'h5000 + 32'(16*i))); end
         end
      end
   endtask

   task automatic test_reset_midrun();
      int ab;
      lat = 10; read_in = 1'b0;
      ab = n_acc;
      do_start(32'h6000, 24'd2);
      repeat (3) tick();
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", busy); end
      tests++; if (av_address !== 32'h6020) begin fails++; $display("FAIL mid_addr: got %h want 00006020", av_address); end
      tests++; if (n_acc - ab !== 2) begin fails++; $display("FAIL mid_pending: got %0d want 2", n_acc - ab); end
      #2 reset = 1'b1;
      #1;
      tests++; if (av_read !== 1'b0) begin fails++; $display("FAIL mid_rst_read: got %b want 0", av_read); end
      tests++; if (av_address !== 32'h0) begin fails++; $display("FAIL mid_rst_addr: got %h want 0", av_address); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL mid_rst_stall: got %b want 1", stall_out); end
      tests++; if (data_out !== '0) begin fails++; $display("FAIL mid_rst_data: got %h want 0", data_out); end
      repeat (2) tick();
      reset = 1'b0;
      repeat (15) tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_post_busy: got %b want 0", busy); end
      tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL mid_post_stall: got %b want 1", stall_out); end
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      word_count = '0;
      read_in    = 1'b0;
      clear      = 1'b0;
      #1 reset = 1'b1;
      test_reset();
      test_basic();
      test_waitrequest();
      test_backpressure();
      test_latency();
      test_clear();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
